// File: rtl/hive_alu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hive_alu_div_pkg
// Brief   : Shared width and state encoding for the iterative divider.
// Revision: 1.0 - initial release
// ============================================================================
package hive_alu_div_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/hive_alu_div_if.sv
`default_nettype none
// ============================================================================
// Module  : hive_alu_div_if
// Brief   : Request/result bundle between an issuing thread and the divider.
// Revision: 1.0 - initial release
// ============================================================================
interface hive_alu_div_if
  import hive_alu_div_pkg::*;
#(
  parameter int WIDTH = ALU_W
);

  logic             start_i;
  logic             sgn_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] quo_o;
  logic [WIDTH-1:0] rem_o;
  logic             dz_o;

  modport master (
    output start_i, sgn_i, a_i, b_i,
    input  ready_o, valid_o, quo_o, rem_o, dz_o
  );

  modport slave (
    input  start_i, sgn_i, a_i, b_i,
    output ready_o, valid_o, quo_o, rem_o, dz_o
  );

endinterface
`default_nettype wire

// File: rtl/hive_alu_div.sv
`default_nettype none
// ============================================================================
// Module  : hive_alu_div
// Brief   : Iterative restoring divider, one quotient bit per clock, signed or
//           unsigned. Define HIVE_DIV_REM_EN to make the remainder output live.
// Revision: 1.0 - initial release
// ============================================================================
module hive_alu_div
  import hive_alu_div_pkg::*;
#(
  parameter int ALU_W = hive_alu_div_pkg::ALU_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hive_alu_div_if.slave      dv
);

  localparam int CNT_W = $clog2(ALU_W);

  function automatic logic [ALU_W-1:0] negate(input logic [ALU_W-1:0] x);
    return '0 - x;
  endfunction

  function automatic logic [ALU_W-1:0] magnitude(input logic [ALU_W-1:0] x, input logic sgn);
    return (sgn && x[ALU_W-1]) ? negate(x) : x;
  endfunction

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ALU_W-1:0]  r_q, r_d;
  logic [ALU_W-1:0]  q_q, q_d;
  logic [ALU_W-1:0]  b_q, b_d;
  logic              quo_neg_q, quo_neg_d;
  logic              dz_q, dz_d;
  logic              valid_q, valid_d;
  logic [ALU_W-1:0]  quo_out_q, quo_out_d;
  logic              dz_out_q, dz_out_d;
`ifdef HIVE_DIV_REM_EN
  logic              rem_neg_q, rem_neg_d;
  logic [ALU_W-1:0]  a_q, a_d;
  logic [ALU_W-1:0]  rem_out_q, rem_out_d;
`endif

  // Restoring step: the borrow of the ALU_W+1-bit difference doubles as r >= |b|.
  logic [ALU_W:0]    step_shift;
  logic [ALU_W:0]    step_diff;
  logic              step_fits;
  logic [ALU_W-1:0]  step_r;

  always_comb begin
    step_shift = {r_q, q_q[ALU_W-1]};
    step_diff  = step_shift - {1'b0, b_q};
    step_fits  = ~step_diff[ALU_W];
    step_r     = step_fits ? step_diff[ALU_W-1:0] : step_shift[ALU_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    b_d       = b_q;
    quo_neg_d = quo_neg_q;
    dz_d      = dz_q;
    valid_d   = 1'b0;
    quo_out_d = quo_out_q;
    dz_out_d  = dz_out_q;
`ifdef HIVE_DIV_REM_EN
    rem_neg_d = rem_neg_q;
    a_d       = a_q;
    rem_out_d = rem_out_q;
`endif
    unique case (state_q)
      DIV_IDLE: begin
        if (dv.start_i) begin
          q_d       = magnitude(dv.a_i, dv.sgn_i);
          b_d       = magnitude(dv.b_i, dv.sgn_i);
          r_d       = '0;
          quo_neg_d = dv.sgn_i & (dv.a_i[ALU_W-1] ^ dv.b_i[ALU_W-1]);
          dz_d      = (dv.b_i == '0);
          cnt_d     = CNT_W'(ALU_W - 1);
          state_d   = DIV_CALC;
`ifdef HIVE_DIV_REM_EN
          rem_neg_d = dv.sgn_i & dv.a_i[ALU_W-1];
          a_d       = dv.a_i;
`endif
        end
      end
      DIV_CALC: begin
        r_d   = step_r;
        q_d   = {q_q[ALU_W-2:0], step_fits};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        valid_d   = 1'b1;
        state_d   = DIV_IDLE;
        quo_out_d = dz_q ? '1 : (quo_neg_q ? negate(q_q) : q_q);
        dz_out_d  = dz_q;
`ifdef HIVE_DIV_REM_EN
        rem_out_d = dz_q ? a_q : (rem_neg_q ? negate(r_q) : r_q);
`endif
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      quo_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      valid_q   <= 1'b0;
      quo_out_q <= '0;
      dz_out_q  <= 1'b0;
`ifdef HIVE_DIV_REM_EN
      rem_neg_q <= 1'b0;
      a_q       <= '0;
      rem_out_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      b_q       <= b_d;
      quo_neg_q <= quo_neg_d;
      dz_q      <= dz_d;
      valid_q   <= valid_d;
      quo_out_q <= quo_out_d;
      dz_out_q  <= dz_out_d;
`ifdef HIVE_DIV_REM_EN
      rem_neg_q <= rem_neg_d;
      a_q       <= a_d;
      rem_out_q <= rem_out_d;
`endif
    end
  end

  assign dv.ready_o = (state_q == DIV_IDLE);
  assign dv.valid_o = valid_q;
  assign dv.quo_o   = quo_out_q;
  assign dv.dz_o    = dz_out_q;
`ifdef HIVE_DIV_REM_EN
  assign dv.rem_o   = rem_out_q;
`else
  assign dv.rem_o   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hive_alu_div.sv
`default_nettype none
// ============================================================================
// Module  : tb_hive_alu_div
// Brief   : Self-checking bench for hive_alu_div against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hive_alu_div;
  import hive_alu_div_pkg::*;

  localparam int W = ALU_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hive_alu_div_if #(.WIDTH(W)) dv ();

  hive_alu_div #(.ALU_W(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .dv    (dv)
  );

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;
    longint       due;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         pend[$];
  longint       cyc = 0;
  bit           armed = 1'b0;
  logic [W-1:0] last_quo = '0;
  logic [W-1:0] last_rem = '0;
  logic         last_dz  = 1'b0;

  // Reference: 64-bit integer division truncates toward zero and cannot overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t   e;
    longint sa, sb, q, r;
    e.due = 0;
    if (b == '0) begin
      e.quo = '1;
      e.rem = a;
      e.dz  = 1'b1;
    end else begin
      sa    = sgn ? longint'($signed(a)) : longint'(a);
      sb    = sgn ? longint'($signed(b)) : longint'(b);
      q     = sa / sb;
      r     = sa % sb;
      e.quo = q[W-1:0];
      e.rem = r[W-1:0];
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rem_vis(input logic [W-1:0] r);
`ifdef HIVE_DIV_REM_EN
    return r;
`else
    return (r & '0);
`endif
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Model update at each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
        last_quo = '0;
        last_rem = '0;
        last_dz  = 1'b0;
        armed    = 1'b1;
      end else if (dv.start_i && pend.size() == 0) begin
        e     = model(dv.a_i, dv.b_i, dv.sgn_i);
        e.due = cyc + W + 1;
        pend.push_back(e);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    logic exp_v, exp_rdy;
    forever begin
      @(negedge clk);
      if (armed) begin
        exp_v   = (pend.size() > 0) && (pend[0].due == cyc);
        exp_rdy = (pend.size() == 0) || exp_v;
        chk("valid_o", W'(dv.valid_o), W'(exp_v));
        chk("ready_o", W'(dv.ready_o), W'(exp_rdy));
        if (exp_v) begin
          last_quo = pend[0].quo;
          last_rem = rem_vis(pend[0].rem);
          last_dz  = pend[0].dz;
          void'(pend.pop_front());
        end
        chk("quo_o", dv.quo_o, last_quo);
        chk("rem_o", dv.rem_o, last_rem);
        chk("dz_o", W'(dv.dz_o), W'(last_dz));
      end
    end
  end

  task automatic wait_ready(input string name);
    int k = 0;
    @(negedge clk);
    while (!dv.ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) timeout(name);
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz);
    int n = 0;
    wait_ready(name);
    dv.a_i     = a;
    dv.b_i     = b;
    dv.sgn_i   = sgn;
    dv.start_i = 1'b1;
    @(posedge clk);
    #1 dv.start_i = 1'b0;
    dv.a_i = W'($urandom);
    dv.b_i = W'($urandom);
    while (1) begin
      @(negedge clk);
      if (dv.valid_o || n > 100) break;
      @(posedge clk);
      n++;
    end
    if (n > 100) begin
      timeout(name);
    end else begin
      chk({name, "_latency"}, W'(n), W'(W + 1));
      chk({name, "_quo"}, dv.quo_o, eq);
      chk({name, "_rem"}, dv.rem_o, rem_vis(er));
      chk({name, "_dz"}, W'(dv.dz_o), W'(edz));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   sel;
    dv.start_i = 1'b0;
    dv.sgn_i   = 1'b0;
    dv.a_i     = '0;
    dv.b_i     = '0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_ready", W'(dv.ready_o), W'(1));
    chk("reset_valid", W'(dv.valid_o), W'(0));
    chk("reset_quo", dv.quo_o, W'(0));
    chk("reset_rem", dv.rem_o, W'(0));
    chk("reset_dz", W'(dv.dz_o), W'(0));

    e = model(32'd100, 32'd7, 1'b0);
    chk("model_u_quo", e.quo, 32'd14);
    chk("model_u_rem", e.rem, 32'd2);
    e = model(32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("model_s_quo", e.quo, 32'hFFFF_FFFD);
    chk("model_s_rem", e.rem, 32'hFFFF_FFFF);
    e = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("model_ovf_quo", e.quo, 32'h8000_0000);

    directed("u100_7",   32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0);
    directed("s-7_2",    32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    directed("s7_-2",    32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0);
    directed("s_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0);
    directed("u_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0);
    directed("s_dz",     32'h1234,      32'd0,         1'b1, 32'hFFFF_FFFF, 32'h1234,      1'b1);
    directed("u_dz",     32'h1234,      32'd0,         1'b0, 32'hFFFF_FFFF, 32'h1234,      1'b1);

    // start_i held through the busy period with changing operands.
    wait_ready("busy_hold");
    dv.a_i     = 32'd1000;
    dv.b_i     = 32'd3;
    dv.sgn_i   = 1'b0;
    dv.start_i = 1'b1;
    for (int i = 0; i < 2 * (W + 2); i++) begin
      @(posedge clk);
      #1;
      dv.a_i   = W'($urandom);
      dv.b_i   = W'($urandom_range(1, 1000));
      dv.sgn_i = 1'($urandom);
    end
    dv.start_i = 1'b0;
    repeat (W + 5) @(posedge clk);

    // Reset in the middle of a calculation.
    wait_ready("mid_reset");
    dv.a_i     = 32'd5555;
    dv.b_i     = 32'd11;
    dv.sgn_i   = 1'b0;
    dv.start_i = 1'b1;
    @(posedge clk);
    #1 dv.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", W'(dv.ready_o), W'(1));
    chk("abort_valid", W'(dv.valid_o), W'(0));
    chk("abort_quo", dv.quo_o, W'(0));
    chk("abort_rem", dv.rem_o, W'(0));
    chk("abort_dz", W'(dv.dz_o), W'(0));
    repeat (W + 5) @(posedge clk);

    // Randomized traffic with corner-biased operands and stray busy starts.
    for (int t = 0; t < 300; t++) begin
      wait_ready("rand");
      sel      = $urandom_range(0, 7);
      dv.a_i   = W'($urandom);
      dv.b_i   = W'($urandom);
      dv.sgn_i = 1'($urandom);
      case (sel)
        0: dv.b_i = '0;
        1: dv.b_i = ($urandom_range(0, 1) == 0) ? W'(1) : '1;
        2: dv.a_i = 32'h8000_0000;
        3: dv.b_i = W'($urandom_range(1, 17));
        4: dv.a_i = W'($urandom_range(0, 50));
        default: ;
      endcase
      dv.start_i = 1'b1;
      @(posedge clk);
      #1 dv.start_i = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        dv.start_i = 1'($urandom);
        dv.a_i     = W'($urandom);
        dv.b_i     = W'($urandom);
      end
      dv.start_i = 1'b0;
    end
    repeat (W + 5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
